// File: rtl/sram_sync_1r1w.sv
// Simple dual-port synchronous SRAM: one registered read port and one masked
// write port on a single clock. Contents and read register are not reset.
module sram_sync_1r1w #(
    parameter int WIDTH          = 16,
    parameter int DEPTH          = 256,
    parameter int WRITE_GRANULE  = WIDTH,
    parameter int R2W_FORWARDING = 0,
    parameter int W_ADDR         = $clog2(DEPTH),
    parameter int N_GRAN         = WIDTH / WRITE_GRANULE
) (
    input  logic              clk,
    input  logic              i_ren,
    input  logic [W_ADDR-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata,
    input  logic              i_wen,
    input  logic [W_ADDR-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [N_GRAN-1:0] i_wmask
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] w_rd_next;
    logic             w_fwd;

    assign w_fwd = (R2W_FORWARDING != 0) && i_wen && (i_raddr == i_waddr);

    always_comb begin
        w_rd_next = r_mem[i_raddr];
        if (w_fwd) begin
            for (int g = 0; g < N_GRAN; g++) begin
                if (i_wmask[g]) begin
                    w_rd_next[g*WRITE_GRANULE +: WRITE_GRANULE] =
                        i_wdata[g*WRITE_GRANULE +: WRITE_GRANULE];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_wen) begin
            for (int g = 0; g < N_GRAN; g++) begin
                if (i_wmask[g]) begin
                    r_mem[i_waddr][g*WRITE_GRANULE +: WRITE_GRANULE] <=
                        i_wdata[g*WRITE_GRANULE +: WRITE_GRANULE];
                end
            end
        end
    end

    // Read register only moves on a read, so the output holds otherwise.
    always_ff @(posedge clk) begin
        if (i_ren) begin
            r_rdata <= w_rd_next;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_sram_sync.sv
// Show-ahead synchronous FIFO built on a 1R1W SRAM; the SRAM read register
// acts as the head entry, giving a capacity of DEPTH+1.
module fifo_sram_sync #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 256,
    parameter int W_ADDR  = $clog2(DEPTH),
    parameter int W_LEVEL = $clog2(DEPTH + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   w_data,
    input  logic               w_push,
    output logic               w_full,
    output logic [WIDTH-1:0]   r_data,
    input  logic               r_pop,
    output logic               r_empty,
    output logic [W_LEVEL-1:0] level
);

    localparam logic [W_LEVEL-1:0] L_DEPTH = W_LEVEL'(DEPTH);

    logic [W_ADDR-1:0]  r_wptr;
    logic [W_ADDR-1:0]  r_rptr;
    logic [W_LEVEL-1:0] r_mem_count;
    logic               r_head_valid;

    logic w_push_ok;
    logic w_pop_ok;
    logic w_ren;

    assign w_full    = (r_mem_count == L_DEPTH);
    assign r_empty   = !r_head_valid;
    assign level     = r_mem_count + W_LEVEL'(r_head_valid);

    assign w_push_ok = w_push && !w_full;
    assign w_pop_ok  = r_pop && r_head_valid;

    // Refill the head whenever it is vacant or being consumed this cycle.
    assign w_ren = (r_mem_count != '0) && (!r_head_valid || w_pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_mem_count  <= '0;
            r_head_valid <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_ren) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_mem_count <= r_mem_count
                         + W_LEVEL'(w_push_ok)
                         - W_LEVEL'(w_ren);
            if (w_ren) begin
                r_head_valid <= 1'b1;
            end else if (w_pop_ok) begin
                r_head_valid <= 1'b0;
            end
        end
    end

    sram_sync_1r1w #(
        .WIDTH          (WIDTH),
        .DEPTH          (DEPTH),
        .WRITE_GRANULE  (WIDTH),
        .R2W_FORWARDING (0),
        .W_ADDR         (W_ADDR)
    ) u_sram (
        .clk     (clk),
        .i_ren   (w_ren),
        .i_raddr (r_rptr),
        .o_rdata (r_data),
        .i_wen   (w_push_ok),
        .i_waddr (r_wptr),
        .i_wdata (w_data),
        .i_wmask (1'b1)
    );

endmodule

// File: tb/tb_fifo_sram_sync.sv
// Randomized and directed bench for fifo_sram_sync against a queue model.
// DEPTH=4, so the FIFO holds up to 5 entries.
module tb_fifo_sram_sync;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 4;
    localparam int W_ADDR  = $clog2(DEPTH);
    localparam int W_LEVEL = $clog2(DEPTH + 2);

    logic               clk;
    logic               rst;
    logic [WIDTH-1:0]   w_data;
    logic               w_push;
    logic               w_full;
    logic [WIDTH-1:0]   r_data;
    logic               r_pop;
    logic               r_empty;
    logic [W_LEVEL-1:0] level;

    int checks;
    int failures;

    logic [WIDTH-1:0] mq[$];
    bit               mhv;

    fifo_sram_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .w_data  (w_data),
        .w_push  (w_push),
        .w_full  (w_full),
        .r_data  (r_data),
        .r_pop   (r_pop),
        .r_empty (r_empty),
        .level   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus; updates the queue model across the edge.
    task automatic cyc(input bit p, input bit q, input logic [WIDTH-1:0] d,
                       output bit coll);
        bit pa, pp, rd;
        int mc;
        w_push = p;
        r_pop  = q;
        w_data = d;
        mc = mq.size() - (mhv ? 1 : 0);
        pa = p && (mc != DEPTH);
        pp = q && mhv;
        rd = (mc != 0) && (!mhv || pp);
        #1;
        coll = dut.w_ren && dut.w_push_ok && (dut.r_rptr == dut.r_wptr);
        @(posedge clk);
        if (pp) void'(mq.pop_front());
        if (pa) mq.push_back(d);
        if (rd) mhv = 1'b1;
        else if (pp) mhv = 1'b0;
        @(negedge clk);
        w_push = 1'b0;
        r_pop  = 1'b0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        w_push = 1'b0;
        r_pop  = 1'b0;
        w_data = '0;
        mq.delete();
        mhv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (r_empty !== 1'b1 || w_full !== 1'b0 || level !== '0) begin
            failures++;
            $display("FAIL reset: empty=%b full=%b level=%0d want 1 0 0",
                     r_empty, w_full, level);
        end
    endtask

    task automatic test_single();
        bit c;
        do_reset();
        cyc(1, 0, 16'h00A1, c);
        checks++;
        if (r_empty !== 1'b1) begin
            failures++;
            $display("FAIL single_early: empty=%b want 1", r_empty);
        end
        cyc(0, 0, 16'h0, c);
        checks++;
        if (r_empty !== 1'b0 || r_data !== 16'h00A1 || level !== 3'd1) begin
            failures++;
            $display("FAIL single: empty=%b data=%h level=%0d want 0 a1 1",
                     r_empty, r_data, level);
        end
    endtask

    task automatic test_fill_drain();
        bit c;
        do_reset();
        for (int i = 1; i <= 5; i++) cyc(1, 0, 16'(i), c);
        checks++;
        if (w_full !== 1'b1 || level !== 3'd5) begin
            failures++;
            $display("FAIL fill: full=%b level=%0d want 1 5", w_full, level);
        end
        cyc(1, 0, 16'h0006, c);
        checks++;
        if (w_full !== 1'b1 || level !== 3'd5) begin
            failures++;
            $display("FAIL sixth_push: full=%b level=%0d want 1 5",
                     w_full, level);
        end
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (r_empty !== 1'b0 || r_data !== 16'(i)) begin
                failures++;
                $display("FAIL drain[%0d]: empty=%b data=%h want 0 %h",
                         i, r_empty, r_data, 16'(i));
            end
            cyc(0, 1, 16'h0, c);
        end
        checks++;
        if (r_empty !== 1'b1 || level !== '0) begin
            failures++;
            $display("FAIL drained: empty=%b level=%0d want 1 0",
                     r_empty, level);
        end
    endtask

    task automatic test_back_to_back();
        bit c;
        do_reset();
        cyc(1, 0, 16'h0100, c);
        cyc(1, 0, 16'h0101, c);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (level !== 3'd2 || r_empty !== 1'b0 ||
                r_data !== 16'(16'h0100 + i)) begin
                failures++;
                $display("FAIL b2b[%0d]: level=%0d data=%h want 2 %h",
                         i, level, r_data, 16'(16'h0100 + i));
            end
            cyc(1, 1, 16'(16'h0102 + i), c);
        end
        checks++;
        if (level !== 3'd2 || r_data !== 16'h0114) begin
            failures++;
            $display("FAIL b2b_end: level=%0d data=%h want 2 0114",
                     level, r_data);
        end
        checks++;
        if (dut.r_wptr !== W_ADDR'(22 % DEPTH) ||
            dut.r_rptr !== W_ADDR'(21 % DEPTH)) begin
            failures++;
            $display("FAIL b2b_wrap: wptr=%0d rptr=%0d want %0d %0d",
                     dut.r_wptr, dut.r_rptr, 22 % DEPTH, 21 % DEPTH);
        end
    endtask

    task automatic test_empty_full();
        bit c;
        do_reset();
        cyc(0, 1, 16'h0, c);
        checks++;
        if (r_empty !== 1'b1 || level !== '0 || w_full !== 1'b0) begin
            failures++;
            $display("FAIL pop_empty: empty=%b level=%0d full=%b want 1 0 0",
                     r_empty, level, w_full);
        end
        for (int i = 0; i < 5; i++) cyc(1, 0, 16'(16'h0010 + i), c);
        checks++;
        if (w_full !== 1'b1 || r_data !== 16'h0010) begin
            failures++;
            $display("FAIL full_pre: full=%b data=%h want 1 0010",
                     w_full, r_data);
        end
        cyc(1, 1, 16'h00EE, c);
        checks++;
        if (level !== 3'd4 || w_full !== 1'b0 || r_data !== 16'h0011) begin
            failures++;
            $display("FAIL full_pushpop: level=%0d full=%b data=%h want 4 0 0011",
                     level, w_full, r_data);
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (r_data !== 16'(16'h0010 + i)) begin
                failures++;
                $display("FAIL full_drain[%0d]: data=%h want %h",
                         i, r_data, 16'(16'h0010 + i));
            end
            cyc(0, 1, 16'h0, c);
        end
        checks++;
        if (r_empty !== 1'b1) begin
            failures++;
            $display("FAIL full_drained: empty=%b want 1", r_empty);
        end
    endtask

    task automatic test_async_reset();
        bit c;
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, 16'(16'h0030 + i), c);
        cyc(0, 0, 16'h0, c);
        checks++;
        if (level !== 3'd3) begin
            failures++;
            $display("FAIL arst_pre: level=%0d want 3", level);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (r_empty !== 1'b1 || w_full !== 1'b0 || level !== '0) begin
            failures++;
            $display("FAIL arst: empty=%b full=%b level=%0d want 1 0 0",
                     r_empty, w_full, level);
        end
        mq.delete();
        mhv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 0, 16'h005A, c);
        cyc(0, 0, 16'h0, c);
        checks++;
        if (r_empty !== 1'b0 || r_data !== 16'h005A || level !== 3'd1) begin
            failures++;
            $display("FAIL arst_after: empty=%b data=%h level=%0d want 0 5a 1",
                     r_empty, r_data, level);
        end
    endtask

    task automatic test_random();
        bit c, p, q, exp_full;
        int pp, qp;
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            exp_full = (mq.size() - (mhv ? 1 : 0)) == DEPTH;
            checks++;
            if (r_empty !== !mhv || w_full !== exp_full ||
                level !== W_LEVEL'(mq.size()) ||
                (mhv && r_data !== mq[0])) begin
                failures++;
                $display("FAIL rand[%0d]: empty=%b full=%b level=%0d data=%h want %b %b %0d %h",
                         i, r_empty, w_full, level, r_data,
                         !mhv, exp_full, mq.size(), mhv ? mq[0] : '0);
            end
            pp = ((i / 500) % 3 == 0) ? 80 : ((i / 500) % 3 == 1) ? 30 : 55;
            qp = 100 - pp;
            p = $urandom_range(0, 99) < pp;
            q = $urandom_range(0, 99) < qp;
            cyc(p, q, 16'($urandom), c);
            checks++;
            if (c !== 1'b0) begin
                failures++;
                $display("FAIL rand_coll[%0d]: same-address read/write=%b want 0",
                         i, c);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        w_push   = 1'b0;
        r_pop    = 1'b0;
        w_data   = '0;
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_empty_full();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_sram_sync.md
FIFO_SRAM_SYNC -- requirements
Module: fifo_sram_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, meaning SRAM entries; a power of two, at least 2.
REQ-003 SHALL have parameter W_ADDR, default $clog2(DEPTH), meaning SRAM address width; left at its default.
REQ-004 SHALL have parameter W_LEVEL, default $clog2(DEPTH+2), meaning level width; left at its default.
REQ-005 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port w_data  input  WIDTH  push data.
REQ-008 SHALL have port w_push  input  1  push request.
REQ-009 SHALL have port w_full  output  1  push will be ignored.
REQ-010 SHALL have port r_data  output  WIDTH  head entry, show-ahead; valid when r_empty=0.
REQ-011 SHALL have port r_pop  input  1  consume head.
REQ-012 SHALL have port r_empty  output  1  no head entry is available.
REQ-013 SHALL have port level  output  W_LEVEL  total entries held.

Function
REQ-014 SHALL hold entries in one sram_sync_1r1w (WRITE_GRANULE=WIDTH, R2W_FORWARDING=0), with r_data driven directly from its read-data register; capacity is DEPTH+1 (DEPTH in SRAM plus 1 head).
REQ-015 SHALL keep registered wptr and rptr (W_ADDR bits, wrap modulo DEPTH), mem_count (0..DEPTH, entries in SRAM excluding head) and head_valid.
REQ-016 SHALL accept a push iff w_push && !w_full: write w_data at wptr, wptr+1.
REQ-017 SHALL accept a pop iff r_pop && head_valid; a pop while r_empty has no effect.
REQ-018 SHALL issue an SRAM read (ren=1, raddr=rptr, rptr+1) iff mem_count!=0 && (!head_valid || pop accepted); ren SHALL be 0 otherwise, so r_data holds.
REQ-019 SHALL set head_valid next cycle if a read issued, clear it if a pop was accepted with no read, and otherwise hold it.
REQ-020 SHALL update mem_count as +1 on push and -1 on read issue, with both applying in the same cycle.
REQ-021 SHALL drive w_full = (mem_count==DEPTH) and r_empty = !head_valid, both registered-state only with no combinational path from w_push or r_pop.
REQ-022 SHALL ignore a push while w_full even if a pop is accepted in the same cycle.
REQ-023 SHALL drive level = mem_count + head_valid.
REQ-024 SHALL give push-to-visible latency of 2 cycles into an empty FIFO: push at edge N, read at edge N+1, r_empty=0 after edge N+1.
REQ-025 SHALL never read and write the same SRAM address in one cycle: a read requires mem_count>0 before the push, and wptr==rptr with mem_count>0 implies full.
REQ-026 SHALL sustain one push and one pop per cycle in steady state, with no bubble while mem_count>0.

Reset
REQ-027 SHALL, on rst, asynchronously clear wptr, rptr, mem_count and head_valid, giving r_empty=1, w_full=0, level=0.
REQ-028 SHALL leave r_data undefined after reset, including mid-operation, until the first read completes; SRAM contents are not cleared.

Structure
REQ-029 SHALL need no shared package; all constants are local parameters.
REQ-030 SHALL instantiate exactly one sub-module, sram_sync_1r1w.

Verification
REQ-031 SHALL cover: DEPTH=4, reset, push 0xA1 once -> r_empty=0 exactly 2 edges later, r_data=0xA1, level=1.
REQ-032 SHALL cover: push 5 values 1..5 with no pops -> w_full=1 after the 5th, level=5; a 6th push is ignored; pop all -> r_data sequence 1,2,3,4,5, then r_empty=1.
REQ-033 SHALL cover: simultaneous push and pop every cycle for 20 cycles from level=2 -> level stays 2, data in order, pointers wrap.
REQ-034 SHALL cover: pop while empty, and push with pop while full -> state unchanged on empty; on full the pop succeeds, the push is dropped, level=4.
REQ-035 SHALL cover: assert rst mid-stream at level=3 -> r_empty=1, w_full=0, level=0 immediately (asynchronously); the next push 0x5A reads back 0x5A.
REQ-036 SHALL cover: random push/pop for 10k cycles against a queue model -> no data mismatch, and never ren&&wen with raddr==waddr.
